reg_bank_wb: RTL

- 32 x 32-bit general-purpose register bank; the consumer of the write-back datapath.
- The write-data select mux in front of it chooses the write-back source (ALUOut, MDR, HI/LO, shifter, constant 227 ...). That mux output drives WriteData here.
- WriteData is committed on the clock edge when RegWrite is high.
- Two asynchronous read ports feed the A/B operand registers; $zero is hardwired and the stack pointer has a nonzero reset value.

---
 rtl/reg_bank_wb_pkg.sv | 31 +++
 rtl/reg_bank_wb_read_port.sv | 29 ++
 rtl/reg_bank_wb.sv | 70 +++++++
 3 files changed

// File: rtl/reg_bank_wb_pkg.sv
// Shared register-file constants and write-back mux select codes, used by the
// register bank, its read ports, the control FSM and the write-data mux.
package reg_bank_wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
    localparam logic [REG_IDX_W-1:0] SP_REG   = 5'd29;
    localparam logic [REG_IDX_W-1:0] RA_REG   = 5'd31;

    // Same value the write-back mux offers as a constant on MTR_CONST227.
    localparam logic [DATA_W-1:0] SP_RESET_VAL = 32'd227;

    // MemToReg select codes for the write-data mux in front of the bank.
    typedef enum logic [3:0] {
        MTR_ALUOUT   = 4'd0,
        MTR_MDR      = 4'd1,
        MTR_HI       = 4'd2,
        MTR_LO       = 4'd3,
        MTR_SHIFT    = 4'd4,
        MTR_SLT      = 4'd5,
        MTR_LUI      = 4'd6,
        MTR_PC       = 4'd7,
        MTR_ALURES   = 4'd8,
        MTR_MDR_BYTE = 4'd9,
        MTR_MDR_HALF = 4'd10,
        MTR_CONST227 = 4'd11
    } mem_to_reg_e;

endpackage

// File: rtl/reg_bank_wb_read_port.sv
// One combinational read port: $zero is hardwired, and an optional forwarding
// path returns the value being written this cycle.
module reg_read_port
    import reg_bank_wb_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [DATA_W-1:0]    regs [NREGS],
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [DATA_W-1:0]    rd_data
);

    always_comb begin
        // NOTE: defaulting every always_comb output first keeps a missed branch from inferring a latch.
        rd_data = '0;
        if (rd_idx == ZERO_REG) begin
            rd_data = '0;
        end else if (BYPASS && wr_en && (rd_idx == wr_idx)) begin
            rd_data = wr_data;
        end else if (int'(rd_idx) < NREGS) begin
            rd_data = regs[rd_idx];
        end
    end

endmodule

// File: rtl/reg_bank_wb.sv
// 32 x 32-bit general-purpose register bank fed by the write-back mux, with two
// asynchronous read ports, a hardwired $zero and a seeded stack pointer.
module reg_bank_wb
    import reg_bank_wb_pkg::*;
#(
    parameter int                NREGS    = 32,
    parameter int                SP_INDEX = int'(SP_REG),
    parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_VAL,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 RegWrite,
    input  logic [REG_IDX_W-1:0] WriteReg,
    input  logic [DATA_W-1:0]    WriteData,
    input  logic [REG_IDX_W-1:0] ReadReg1,
    input  logic [REG_IDX_W-1:0] ReadReg2,
    output logic [DATA_W-1:0]    ReadData1,
    output logic [DATA_W-1:0]    ReadData2,
    output logic [15:0]          WriteCount,
    output logic [REG_IDX_W-1:0] LastWrite
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    // Writes to $zero are dropped entirely: no storage update, no bookkeeping.
    assign commit = RegWrite && (WriteReg != ZERO_REG) && (int'(WriteReg) < NREGS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the array is reset on purpose; software relies on defined zeros and a seeded SP.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
            WriteCount <= '0;
            LastWrite  <= '0;
        end else if (commit) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            regs[WriteReg] <= WriteData;
            WriteCount     <= WriteCount + 16'd1;
            LastWrite      <= WriteReg;
        end
    end

    reg_read_port #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_port1 (
        .rd_idx  (ReadReg1),
        .regs    (regs),
        .wr_en   (RegWrite),
        .wr_idx  (WriteReg),
        .wr_data (WriteData),
        .rd_data (ReadData1)
    );

    reg_read_port #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_port2 (
        .rd_idx  (ReadReg2),
        .regs    (regs),
        .wr_en   (RegWrite),
        .wr_idx  (WriteReg),
        .wr_data (WriteData),
        .rd_data (ReadData2)
    );

endmodule
